// File: rtl/gtx_reset_seq.sv
// gtx_reset_seq: CPLL / TX / RX reset and bring-up sequencer for GTXE2 lanes.
// Retries the CPLL reset on lock timeout and re-sequences all lanes on lock loss.
module gtx_reset_seq #(
    parameter int LANES           = 1,
    parameter int CPLLRST_CYCLES  = 8,
    parameter int LOCK_TIMEOUT    = 1024,
    parameter int TXPMARESET_TIME = 1,
    parameter int RXEYERESET_TIME = 19,
    parameter int CNT_WIDTH       = 11
) (
    input  logic             gtrefclk,
    input  logic             extrst,
    input  logic [LANES-1:0] cplllock,
    input  logic             usrpll_locked,
    input  logic             sata_reset_done,
    input  logic [LANES-1:0] txreset_req,
    input  logic [LANES-1:0] rxreset_req,
    input  logic [LANES-1:0] txresetdone,
    input  logic [LANES-1:0] rxresetdone,
    output logic             cpllreset,
    output logic [LANES-1:0] txreset,
    output logic [LANES-1:0] rxreset,
    output logic [LANES-1:0] txuserrdy,
    output logic [LANES-1:0] rxuserrdy,
    output logic [LANES-1:0] gtx_ready,
    output logic             gtx_configured,
    output logic             lock_timeout,
    output logic [3:0]       retry_cnt
);

    localparam int SW  = 5 * LANES + 2;
    localparam int TXW = (TXPMARESET_TIME > 0) ? $clog2(TXPMARESET_TIME + 1) : 1;
    localparam int RXW = (RXEYERESET_TIME > 0) ? $clog2(RXEYERESET_TIME + 1) : 1;

    localparam logic [CNT_WIDTH-1:0] RST_LAST = CNT_WIDTH'(CPLLRST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [TXW-1:0]       TX_SAT   = TXW'(TXPMARESET_TIME);
    localparam logic [RXW-1:0]       RX_SAT   = RXW'(RXEYERESET_TIME);

    typedef enum logic [1:0] {
        CPLL_RST  = 2'd0,
        WAIT_LOCK = 2'd1,
        RUN       = 2'd2
    } state_t;

    logic [SW-1:0]    async_v;
    logic [SW-1:0]    meta_q;
    logic [SW-1:0]    sync_q;
    logic [LANES-1:0] lock_s;
    logic [LANES-1:0] txreq_s;
    logic [LANES-1:0] rxreq_s;
    logic [LANES-1:0] txdone_s;
    logic [LANES-1:0] rxdone_s;
    logic             usrpll_s;
    logic             sata_s;
    logic             lock_all_s;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   timer_q, timer_d;
    logic                   tmo_q, tmo_d;
    logic [3:0]             retry_q, retry_d;
    logic [3:0]             retry_inc;

    logic [LANES-1:0] txreset_q, txreset_d;
    logic [LANES-1:0] rxreset_q, rxreset_d;
    logic [LANES-1:0] txuserrdy_q, txuserrdy_d;
    logic [LANES-1:0] rxuserrdy_q, rxuserrdy_d;
    logic [LANES-1:0] ready_q, ready_d;
    logic             cfg_q, cfg_d;
    logic [TXW-1:0]   tx_cnt_q [LANES];
    logic [TXW-1:0]   tx_cnt_d [LANES];
    logic [RXW-1:0]   rx_cnt_q [LANES];
    logic [RXW-1:0]   rx_cnt_d [LANES];
    logic [LANES-1:0] tx_done;
    logic [LANES-1:0] rx_done;
    logic             base_ok;

    assign async_v = {rxresetdone, txresetdone, rxreset_req, txreset_req,
                      sata_reset_done, usrpll_locked, cplllock};
    assign {rxdone_s, txdone_s, rxreq_s, txreq_s,
            sata_s, usrpll_s, lock_s} = sync_q;
    assign lock_all_s = &lock_s;

    // Two-flop synchronisers for every asynchronous input.
    always_ff @(posedge gtrefclk or posedge extrst) begin
        if (extrst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_v;
            sync_q <= meta_q;
        end
    end

    assign retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

    // Global sequencer: CPLL reset pulse, lock wait with timeout, run.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        unique case (state_q)
            CPLL_RST: begin
                if (timer_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lock_all_s) begin
                    state_d = RUN;
                    timer_d = '0;
                end else if (timer_q == TMO_LAST) begin
                    state_d = CPLL_RST;
                    timer_d = '0;
                    tmo_d   = 1'b1;
                    retry_d = retry_inc;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RUN: begin
                timer_d = '0;
                if (!lock_all_s) begin
                    state_d = CPLL_RST;
                    retry_d = retry_inc;
                end
            end
            default: begin
                state_d = CPLL_RST;
                timer_d = '0;
            end
        endcase
    end

    // Sequencer state, timer and sticky status registers.
    always_ff @(posedge gtrefclk or posedge extrst) begin
        if (extrst) begin
            state_q <= CPLL_RST;
            timer_q <= '0;
            tmo_q   <= 1'b0;
            retry_q <= 4'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            tmo_q   <= tmo_d;
            retry_q <= retry_d;
        end
    end

    // Settle counters have finished once they sit at their saturation value.
    always_comb begin
        tx_done = '0;
        rx_done = '0;
        for (int i = 0; i < LANES; i++) begin
            tx_done[i] = (tx_cnt_q[i] == TX_SAT);
            rx_done[i] = (rx_cnt_q[i] == RX_SAT);
        end
    end

    // Per-lane resets, settle counters, user-ready and lane-ready.
    always_comb begin
        base_ok     = usrpll_s & sata_s & (state_q == RUN);
        txreset_d   = '1;
        rxreset_d   = '1;
        txuserrdy_d = '0;
        rxuserrdy_d = '0;
        ready_d     = '0;
        for (int i = 0; i < LANES; i++) begin
            tx_cnt_d[i]    = '0;
            rx_cnt_d[i]    = '0;
            txreset_d[i]   = (state_q != RUN) | txreq_s[i];
            rxreset_d[i]   = (state_q != RUN) | (rxreq_s[i] & cfg_q);
            if (!txreset_q[i])
                tx_cnt_d[i] = tx_done[i] ? tx_cnt_q[i] : tx_cnt_q[i] + 1'b1;
            if (!rxreset_q[i])
                rx_cnt_d[i] = rx_done[i] ? rx_cnt_q[i] : rx_cnt_q[i] + 1'b1;
            txuserrdy_d[i] = base_ok & ~txreset_q[i] & tx_done[i];
            rxuserrdy_d[i] = base_ok & ~rxreset_q[i] & rx_done[i];
            ready_d[i]     = txuserrdy_q[i] & rxuserrdy_q[i]
                           & txdone_s[i] & rxdone_s[i];
        end
        cfg_d = cfg_q | (&ready_d);
    end

    // Per-lane output and counter registers.
    always_ff @(posedge gtrefclk or posedge extrst) begin
        if (extrst) begin
            txreset_q   <= '1;
            rxreset_q   <= '1;
            txuserrdy_q <= '0;
            rxuserrdy_q <= '0;
            ready_q     <= '0;
            cfg_q       <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                tx_cnt_q[i] <= '0;
                rx_cnt_q[i] <= '0;
            end
        end else begin
            txreset_q   <= txreset_d;
            rxreset_q   <= rxreset_d;
            txuserrdy_q <= txuserrdy_d;
            rxuserrdy_q <= rxuserrdy_d;
            ready_q     <= ready_d;
            cfg_q       <= cfg_d;
            for (int i = 0; i < LANES; i++) begin
                tx_cnt_q[i] <= tx_cnt_d[i];
                rx_cnt_q[i] <= rx_cnt_d[i];
            end
        end
    end

    assign cpllreset      = (state_q == CPLL_RST);
    assign txreset        = txreset_q;
    assign rxreset        = rxreset_q;
    assign txuserrdy      = txuserrdy_q;
    assign rxuserrdy      = rxuserrdy_q;
    assign gtx_ready      = ready_q;
    assign gtx_configured = cfg_q;
    assign lock_timeout   = tmo_q;
    assign retry_cnt      = retry_q;

endmodule

// File: tb/tb_gtx_reset_seq.sv
// tb_gtx_reset_seq: directed bring-up / timeout / lane / async-reset scenarios
// plus a randomized run checked against a behavioural model.
module tb_gtx_reset_seq;

    localparam int L   = 2;
    localparam int CR  = 8;
    localparam int LT  = 16;
    localparam int TXT = 1;
    localparam int RXT = 19;

    logic         clk = 1'b0;
    logic         extrst = 1'b1;
    logic [L-1:0] cplllock;
    logic         usr;
    logic         sata;
    logic [L-1:0] treq;
    logic [L-1:0] rreq;
    logic [L-1:0] tdone;
    logic [L-1:0] rdone;

    logic         cpllreset;
    logic [L-1:0] txreset;
    logic [L-1:0] rxreset;
    logic [L-1:0] txu;
    logic [L-1:0] rxu;
    logic [L-1:0] rdy;
    logic         cfg;
    logic         tmo;
    logic [3:0]   retry;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gtx_reset_seq #(
        .LANES(L), .CPLLRST_CYCLES(CR), .LOCK_TIMEOUT(LT),
        .TXPMARESET_TIME(TXT), .RXEYERESET_TIME(RXT), .CNT_WIDTH(11)
    ) dut (
        .gtrefclk(clk), .extrst(extrst), .cplllock(cplllock),
        .usrpll_locked(usr), .sata_reset_done(sata),
        .txreset_req(treq), .rxreset_req(rreq),
        .txresetdone(tdone), .rxresetdone(rdone),
        .cpllreset(cpllreset), .txreset(txreset), .rxreset(rxreset),
        .txuserrdy(txu), .rxuserrdy(rxu), .gtx_ready(rdy),
        .gtx_configured(cfg), .lock_timeout(tmo), .retry_cnt(retry)
    );

    // Behavioural model: inputs seen two edges late, phases with ages,
    // and lane settle measured from the timestamp of each reset fall.
    localparam logic [1:0] P_RST  = 2'd0;
    localparam logic [1:0] P_WAIT = 2'd1;
    localparam logic [1:0] P_RUN  = 2'd2;

    logic [1:0]   ph;
    int           age;
    int           cyc;
    logic [11:0]  m_d1;
    logic [11:0]  m_s;
    logic [11:0]  in_v;
    logic [L-1:0] m_txr, m_rxr, m_txu, m_rxu, m_rdy;
    int           m_txf [L];
    int           m_rxf [L];
    logic         m_cfg, m_tmo;
    int           m_retry;

    logic [L-1:0] s_lock, s_treq, s_rreq, s_tdone, s_rdone;
    logic         s_usr, s_sata, lock_all, base;
    logic [L-1:0] n_txr, n_rxr, n_rdy, t_done, r_done;

    assign in_v = {rdone, tdone, rreq, treq, sata, usr, cplllock};
    assign {s_rdone, s_tdone, s_rreq, s_treq, s_sata, s_usr, s_lock} = m_s;

    always_comb begin
        lock_all = &s_lock;
        base     = s_usr & s_sata & (ph == P_RUN);
        n_txr    = '0;
        n_rxr    = '0;
        n_rdy    = '0;
        t_done   = '0;
        r_done   = '0;
        for (int i = 0; i < L; i++) begin
            n_txr[i]  = (ph != P_RUN) | s_treq[i];
            n_rxr[i]  = (ph != P_RUN) | (s_rreq[i] & m_cfg);
            t_done[i] = !m_txr[i] && ((cyc - m_txf[i]) >= TXT);
            r_done[i] = !m_rxr[i] && ((cyc - m_rxf[i]) >= RXT);
            n_rdy[i]  = m_txu[i] & m_rxu[i] & s_tdone[i] & s_rdone[i];
        end
    end

    always @(posedge clk or posedge extrst) begin
        if (extrst) begin
            ph      <= P_RST;
            age     <= 0;
            cyc     <= 0;
            m_d1    <= '0;
            m_s     <= '0;
            m_txr   <= '1;
            m_rxr   <= '1;
            m_txu   <= '0;
            m_rxu   <= '0;
            m_rdy   <= '0;
            m_cfg   <= 1'b0;
            m_tmo   <= 1'b0;
            m_retry <= 0;
            for (int i = 0; i < L; i++) begin
                m_txf[i] <= 0;
                m_rxf[i] <= 0;
            end
        end else begin
            cyc   <= cyc + 1;
            m_d1  <= in_v;
            m_s   <= m_d1;
            m_txr <= n_txr;
            m_rxr <= n_rxr;
            m_txu <= {L{base}} & ~m_txr & t_done;
            m_rxu <= {L{base}} & ~m_rxr & r_done;
            m_rdy <= n_rdy;
            m_cfg <= m_cfg | (&n_rdy);
            for (int i = 0; i < L; i++) begin
                if (m_txr[i] && !n_txr[i]) m_txf[i] <= cyc + 1;
                if (m_rxr[i] && !n_rxr[i]) m_rxf[i] <= cyc + 1;
            end
            case (ph)
                P_RST: begin
                    if (age == CR - 1) begin
                        ph  <= P_WAIT;
                        age <= 0;
                    end else begin
                        age <= age + 1;
                    end
                end
                P_WAIT: begin
                    if (lock_all) begin
                        ph  <= P_RUN;
                        age <= 0;
                    end else if (age == LT - 1) begin
                        ph      <= P_RST;
                        age     <= 0;
                        m_tmo   <= 1'b1;
                        m_retry <= (m_retry < 15) ? m_retry + 1 : 15;
                    end else begin
                        age <= age + 1;
                    end
                end
                default: begin
                    if (!lock_all) begin
                        ph      <= P_RST;
                        m_retry <= (m_retry < 15) ? m_retry + 1 : 15;
                    end
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string w);
        chk({w, ".cpllreset"}, 32'(cpllreset), 32'(ph == P_RST));
        chk({w, ".txreset"},   32'(txreset),   32'(m_txr));
        chk({w, ".rxreset"},   32'(rxreset),   32'(m_rxr));
        chk({w, ".txuserrdy"}, 32'(txu),       32'(m_txu));
        chk({w, ".rxuserrdy"}, 32'(rxu),       32'(m_rxu));
        chk({w, ".gtx_ready"}, 32'(rdy),       32'(m_rdy));
        chk({w, ".configured"}, 32'(cfg),      32'(m_cfg));
        chk({w, ".lock_timeout"}, 32'(tmo),    32'(m_tmo));
        chk({w, ".retry_cnt"}, 32'(retry),     32'(m_retry));
    endtask

    task automatic chk_rst(input string w);
        chk({w, ".cpllreset"}, 32'(cpllreset), 32'd1);
        chk({w, ".txreset"},   32'(txreset),   32'd3);
        chk({w, ".rxreset"},   32'(rxreset),   32'd3);
        chk({w, ".txuserrdy"}, 32'(txu),       32'd0);
        chk({w, ".rxuserrdy"}, 32'(rxu),       32'd0);
        chk({w, ".gtx_ready"}, 32'(rdy),       32'd0);
        chk({w, ".configured"}, 32'(cfg),      32'd0);
        chk({w, ".lock_timeout"}, 32'(tmo),    32'd0);
        chk({w, ".retry_cnt"}, 32'(retry),     32'd0);
    endtask

    task automatic step(input int n, input string w);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            chk_model(w);
        end
    endtask

    // Counts edges from now until each bring-up milestone is observed.
    task automatic bringup(input string w);
        int t_cpl = -1;
        int t_tx  = -1;
        int t_txu = -1;
        int t_rxu = -1;
        int t_rdy = -1;
        int t_cfg = -1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk_model(w);
            if (t_cpl < 0 && !cpllreset)      t_cpl = k;
            if (t_tx  < 0 && txreset == 2'b00) t_tx = k;
            if (t_txu < 0 && txu == 2'b11)    t_txu = k;
            if (t_rxu < 0 && rxu == 2'b11)    t_rxu = k;
            if (t_rdy < 0 && rdy == 2'b11)    t_rdy = k;
            if (t_cfg < 0 && cfg)             t_cfg = k;
        end
        chk({w, ".cpll_fall"}, 32'(t_cpl), 32'(CR));
        chk({w, ".txreset_fall"}, 32'(t_tx), 32'(CR + 2));
        chk({w, ".txuserrdy_rise"}, 32'(t_txu), 32'(CR + 2 + TXT + 1));
        chk({w, ".rxuserrdy_rise"}, 32'(t_rxu), 32'(CR + 2 + RXT + 1));
        chk({w, ".ready_rise"}, 32'(t_rdy), 32'(CR + 2 + RXT + 2));
        chk({w, ".configured_rise"}, 32'(t_cfg), 32'(CR + 2 + RXT + 2));
    endtask

    initial begin
        int t_r1;
        int t_f1;
        int t_b1;
        logic lane0_ok;

        cplllock = '1;
        usr      = 1'b1;
        sata     = 1'b1;
        treq     = '0;
        rreq     = '0;
        tdone    = '1;
        rdone    = '1;
        repeat (3) @(negedge clk);
        chk_rst("reset");

        // Normal bring-up with everything already good.
        extrst = 1'b0;
        bringup("bringup");

        // Lock held low: three timeout loops, then lock arrives.
        extrst = 1'b1;
        cplllock = '0;
        @(negedge clk);
        extrst = 1'b0;
        step(CR + LT - 1, "tmo_wait");
        chk("tmo.before_first", 32'(retry), 32'd0);
        step(1, "tmo_first");
        chk("tmo.first_flag", 32'(tmo), 32'd1);
        step(2 * (CR + LT) - 1, "tmo_loops");
        chk("tmo.retry_two", 32'(retry), 32'd2);
        step(1, "tmo_third");
        chk("tmo.retry_three", 32'(retry), 32'd3);
        chk("tmo.cpll_again", 32'(cpllreset), 32'd1);
        cplllock = '1;
        bringup("tmo_bringup");
        chk("tmo.sticky", 32'(tmo), 32'd1);
        chk("tmo.retry_kept", 32'(retry), 32'd3);

        // RX request on lane 1 only, five cycles long.
        rreq = 2'b10;
        t_r1 = -1;
        t_f1 = -1;
        t_b1 = -1;
        lane0_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk_model("lane");
            if (k == 5) rreq = 2'b00;
            if (t_r1 < 0 && rxreset[1]) t_r1 = k;
            if (t_r1 >= 0 && t_f1 < 0 && !rxreset[1]) t_f1 = k;
            if (t_f1 >= 0 && t_b1 < 0 && rxu[1]) t_b1 = k;
            if (rxreset[0] || txreset != 2'b00 || !rdy[0] || !rxu[0] || !txu[0])
                lane0_ok = 1'b0;
        end
        chk("lane.rxreset1_rise", 32'(t_r1), 32'd3);
        chk("lane.rxreset1_fall", 32'(t_f1), 32'd8);
        chk("lane.rxuserrdy1_back", 32'(t_b1 - t_f1), 32'(RXT + 1));
        chk("lane.lane0_kept", 32'(lane0_ok), 32'd1);

        // RX requests ignored before the first configuration.
        extrst = 1'b1;
        rreq = 2'b11;
        @(negedge clk);
        extrst = 1'b0;
        step(12, "precfg");
        chk("precfg.rx_ignored", 32'(rxreset), 32'd0);
        rreq = 2'b00;
        step(25, "precfg_up");
        chk("precfg.configured", 32'(cfg), 32'd1);

        // Lock loss on lane 0 while running.
        cplllock = 2'b10;
        step(3, "loss");
        chk("loss.cpll", 32'(cpllreset), 32'd1);
        chk("loss.retry", 32'(retry), 32'd1);
        step(1, "loss_lanes");
        chk("loss.txreset", 32'(txreset), 32'd3);
        chk("loss.txuserrdy", 32'(txu), 32'd0);
        step(1, "loss_ready");
        chk("loss.ready", 32'(rdy), 32'd0);
        chk("loss.cfg_kept", 32'(cfg), 32'd1);

        // Asynchronous reset in the middle of the CPLL countdown.
        @(posedge clk);
        #2;
        extrst = 1'b1;
        #1;
        chk_rst("async_mid");
        cplllock = '1;
        sata = 1'b0;
        @(negedge clk);
        extrst = 1'b0;

        // sata_reset_done low holds userrdy off until it rises.
        step(40, "sata_low");
        chk("sata.txuserrdy_off", 32'(txu), 32'd0);
        chk("sata.rxuserrdy_off", 32'(rxu), 32'd0);
        sata = 1'b1;
        step(2, "sata_sync");
        chk("sata.not_yet", 32'(txu), 32'd0);
        step(1, "sata_up");
        chk("sata.txuserrdy_on", 32'(txu), 32'd3);
        chk("sata.rxuserrdy_on", 32'(rxu), 32'd3);
        step(1, "sata_ready");
        chk("sata.ready", 32'(rdy), 32'd3);

        // Asynchronous reset with the link fully up.
        @(posedge clk);
        #3;
        extrst = 1'b1;
        #1;
        chk_rst("async_up");
        @(negedge clk);
        extrst = 1'b0;

        // Randomized run against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < L; i++) begin
                cplllock[i] = ($urandom_range(0, 80) != 0);
                if ($urandom_range(0, 15) == 0) treq[i] = ~treq[i];
                if ($urandom_range(0, 15) == 0) rreq[i] = ~rreq[i];
                tdone[i] = ($urandom_range(0, 30) != 0);
                rdone[i] = ($urandom_range(0, 30) != 0);
            end
            usr  = ($urandom_range(0, 50) != 0);
            sata = ($urandom_range(0, 50) != 0);
            if (c >= 1000 && c < 1100) cplllock = '0;
            @(posedge clk);
            @(negedge clk);
            chk_model("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
